// File: rtl/fb_txcounters.sv
// Transmit-side counters for the frame builder: per-state cycle counter with
// end-of-state pulses, frame-CRC/IPG counter with done pulse, and data byte count.
module fb_txcounters #(
  parameter int PRE_NIB   = 16,
  parameter int NUMB_NIB  = 4,
  parameter int DIST_NIB  = 8,
  parameter int DELAY_NIB = 8,
  parameter int CRC_NIB   = 8,
  parameter int FCRC_NIB  = 8,
  parameter int IPG_NIB   = 24
) (
  input  logic        MTxClk,
  input  logic        Reset,
  input  logic        StateIdle,
  input  logic        StatePreamble,
  input  logic        StateSoC,
  input  logic        StateNumb,
  input  logic        StateDelay,
  input  logic        StateCrc,
  input  logic        StateFrmCrc,
  input  logic [1:0]  StateDist,
  input  logic [1:0]  StateDelayDist,
  input  logic [1:0]  StateData,
  output logic        PreambleStateEnd,
  output logic        NumbStateEnd,
  output logic        DistStateEnd,
  output logic        DelayStateEnd,
  output logic        CrcStateEnd,
  output logic        StartTxDone,
  output logic [7:0]  StCnt,
  output logic [7:0]  FrmCnt,
  output logic [15:0] ByteCnt
);

  localparam logic [7:0] PRE_END   = 8'(PRE_NIB - 1);
  localparam logic [7:0] NUMB_END  = 8'(NUMB_NIB - 1);
  localparam logic [7:0] DIST_END  = 8'(DIST_NIB - 1);
  localparam logic [7:0] DELAY_END = 8'(DELAY_NIB - 1);
  localparam logic [7:0] CRC_END   = 8'(CRC_NIB - 1);
  localparam logic [7:0] DONE_END  = 8'(FCRC_NIB + IPG_NIB - 1);

  localparam bit CFG_BAD =
    (PRE_NIB   < 1) || (PRE_NIB   > 255) ||
    (NUMB_NIB  < 1) || (NUMB_NIB  > 255) ||
    (DIST_NIB  < 1) || (DIST_NIB  > 255) ||
    (DELAY_NIB < 1) || (DELAY_NIB > 255) ||
    (CRC_NIB   < 1) || (CRC_NIB   > 255) ||
    (FCRC_NIB  < 1) || (IPG_NIB   < 0)   ||
    (FCRC_NIB + IPG_NIB > 255);

  generate
    if (CFG_BAD) begin : g_cfg_err
      $error("fb_txcounters: count limit outside 1..255");
    end
  endgenerate

  logic [7:0]  r_stcnt;
  logic [7:0]  r_frmcnt;
  logic [15:0] r_bytecnt;
  logic        w_any_end;
  logic        w_st_clr;

  assign PreambleStateEnd = StatePreamble & (r_stcnt == PRE_END);
  assign NumbStateEnd     = StateNumb     & (r_stcnt == NUMB_END);
  assign DistStateEnd     = StateDist[1]  & (r_stcnt == DIST_END);
  assign DelayStateEnd    = StateDelay    & (r_stcnt == DELAY_END);
  assign CrcStateEnd      = StateCrc      & (r_stcnt == CRC_END);
  assign StartTxDone      = StateFrmCrc   & (r_frmcnt == DONE_END);

  assign w_any_end = PreambleStateEnd | NumbStateEnd | DistStateEnd |
                     DelayStateEnd | CrcStateEnd;
  // Clearing on the end pulse is what makes each pulse last exactly one cycle.
  assign w_st_clr  = StateIdle | StateSoC | StateDist[0] | StateDelayDist[0] |
                     StateData[0] | StateData[1] | w_any_end;

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset) begin
      r_stcnt <= '0;
    end else if (w_st_clr) begin
      r_stcnt <= '0;
    end else if (r_stcnt != 8'hFF) begin
      r_stcnt <= r_stcnt + 8'd1;
    end
  end

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset) begin
      r_frmcnt <= '0;
    end else if (!StateFrmCrc) begin
      r_frmcnt <= '0;
    end else if (r_frmcnt != 8'hFF) begin
      r_frmcnt <= r_frmcnt + 8'd1;
    end
  end

  // Byte count survives Crc/FrmCrc so it can be read after the payload.
  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset) begin
      r_bytecnt <= '0;
    end else if (StateIdle) begin
      r_bytecnt <= '0;
    end else if (StateData[1]) begin
      r_bytecnt <= r_bytecnt + 16'd1;
    end
  end

  assign StCnt   = r_stcnt;
  assign FrmCnt  = r_frmcnt;
  assign ByteCnt = r_bytecnt;

endmodule

// File: tb/tb_fb_txcounters.sv
// Directed bench for fb_txcounters: walks a frame through every counted state
// and checks counters, end pulses, saturation, wrap and mid-frame reset.
module tb_fb_txcounters;

  logic        MTxClk = 1'b0;
  logic        Reset;
  logic        StateIdle, StatePreamble, StateSoC, StateNumb;
  logic        StateDelay, StateCrc, StateFrmCrc;
  logic [1:0]  StateDist, StateDelayDist, StateData;
  logic        PreambleStateEnd, NumbStateEnd, DistStateEnd;
  logic        DelayStateEnd, CrcStateEnd, StartTxDone;
  logic [7:0]  StCnt, FrmCnt;
  logic [15:0] ByteCnt;

  int n_run  = 0;
  int n_fail = 0;

  fb_txcounters dut (
    .MTxClk(MTxClk), .Reset(Reset),
    .StateIdle(StateIdle), .StatePreamble(StatePreamble), .StateSoC(StateSoC),
    .StateNumb(StateNumb), .StateDelay(StateDelay), .StateCrc(StateCrc),
    .StateFrmCrc(StateFrmCrc), .StateDist(StateDist),
    .StateDelayDist(StateDelayDist), .StateData(StateData),
    .PreambleStateEnd(PreambleStateEnd), .NumbStateEnd(NumbStateEnd),
    .DistStateEnd(DistStateEnd), .DelayStateEnd(DelayStateEnd),
    .CrcStateEnd(CrcStateEnd), .StartTxDone(StartTxDone),
    .StCnt(StCnt), .FrmCnt(FrmCnt), .ByteCnt(ByteCnt)
  );

  always #5 MTxClk = ~MTxClk;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks sit 1 unit later.
  task automatic tick();
    @(posedge MTxClk);
    #2;
  endtask

  task automatic idle_all();
    StateIdle = 0; StatePreamble = 0; StateSoC = 0; StateNumb = 0;
    StateDelay = 0; StateCrc = 0; StateFrmCrc = 0;
    StateDist = 0; StateDelayDist = 0; StateData = 0;
  endtask

  task automatic run_preamble(input string tag);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk({tag, "_stcnt"}, StCnt, i);
      chk({tag, "_end"}, PreambleStateEnd, (i == 15) ? 1 : 0);
      tick();
    end
    #1 chk({tag, "_clr"}, StCnt, 0);
  endtask

  initial begin
    Reset = 1;
    idle_all();
    StateIdle = 1;
    repeat (2) tick();
    #1;
    chk("rst_stcnt", StCnt, 0);
    chk("rst_frmcnt", FrmCnt, 0);
    chk("rst_bytecnt", ByteCnt, 0);
    chk("rst_ends", {PreambleStateEnd, NumbStateEnd, DistStateEnd,
                     DelayStateEnd, CrcStateEnd, StartTxDone}, 0);
    Reset = 0;
    tick();

    StateIdle = 0; StatePreamble = 1;
    run_preamble("pre");

    StatePreamble = 0; StateSoC = 1;
    tick();
    StateSoC = 0; StateNumb = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("numb_end", NumbStateEnd, (i == 3) ? 1 : 0);
      tick();
    end
    #1 chk("numb_clr", StCnt, 0);

    StateNumb = 0; StateSoC = 1;
    tick();
    StateSoC = 0; StateDist = 2'b01;
    #1 chk("dist0_end", DistStateEnd, 0);
    tick();
    StateDist = 2'b10;
    for (int i = 0; i < 8; i++) begin
      #1 chk("dist_end", DistStateEnd, (i == 7) ? 1 : 0);
      tick();
    end

    StateDist = 0; StateDelayDist = 2'b01;
    tick();
    StateDelayDist = 0; StateDelay = 1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("delay_end", DelayStateEnd, (i == 7) ? 1 : 0);
      tick();
    end

    StateDelay = 0;
    for (int i = 0; i < 5; i++) begin
      StateData = 2'b01; tick();
      StateData = 2'b10; tick();
    end
    StateData = 0; StateCrc = 1;
    #1 chk("data_bytecnt", ByteCnt, 5);
    chk("crc_start", StCnt, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) #1;
      chk("crc_end", CrcStateEnd, (i == 7) ? 1 : 0);
      if (i == 7) chk("crc_bytecnt", ByteCnt, 5);
      tick();
    end

    StateCrc = 0; StateFrmCrc = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("frm_done", StartTxDone, (i == 31) ? 1 : 0);
      if (i == 0 || i == 31) chk("frm_cnt", FrmCnt, i);
      tick();
    end
    StateFrmCrc = 0; StateIdle = 1;
    #1 chk("frm_drop_done", StartTxDone, 0);
    tick();
    #1;
    chk("frm_drop_cnt", FrmCnt, 0);
    chk("idle_bytecnt", ByteCnt, 0);

    // Saturation: DelayDist[1] has neither clear nor end pulse.
    StateIdle = 0; StateDelayDist = 2'b10;
    repeat (260) tick();
    #1 chk("stcnt_sat", StCnt, 255);
    StateDelayDist = 0; StateFrmCrc = 1;
    repeat (300) tick();
    #1;
    chk("frmcnt_sat", FrmCnt, 255);
    chk("frm_sat_done", StartTxDone, 0);

    StateFrmCrc = 0; StateIdle = 1;
    tick();
    StateIdle = 0; StateData = 2'b10;
    repeat (65535) tick();
    #1 chk("byte_max", ByteCnt, 16'hFFFF);
    tick();
    #1 chk("byte_wrap", ByteCnt, 0);

    // Mid-frame reset with non-zero counters.
    repeat (2) tick();
    StateData = 0; StatePreamble = 1;
    repeat (5) tick();
    #1;
    chk("mid_stcnt", StCnt, 5);
    chk("mid_bytecnt", ByteCnt, 2);
    #1 Reset = 1;
    #1;
    chk("arst_stcnt", StCnt, 0);
    chk("arst_frmcnt", FrmCnt, 0);
    chk("arst_bytecnt", ByteCnt, 0);
    chk("arst_end", PreambleStateEnd, 0);
    StatePreamble = 0; StateIdle = 1;
    #2 Reset = 0;
    tick();
    StateIdle = 0; StatePreamble = 1;
    run_preamble("pre2");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_txcounters.md
FB_TXCOUNTERS -- requirements
Module: fb_txcounters

Interface
REQ-001 Parameter PRE_NIB, default 16: Preamble state length in MTxClk cycles.
REQ-002 Parameter NUMB_NIB, default 4: Numbering state length in cycles.
REQ-003 Parameter DIST_NIB, default 8: length of StateDist[1] in cycles.
REQ-004 Parameter DELAY_NIB, default 8: Delay state length in cycles.
REQ-005 Parameter CRC_NIB, default 8: length of an intermediate Crc state in cycles.
REQ-006 Parameter FCRC_NIB, default 8, and IPG_NIB, default 24: Frame-Crc length plus inter-frame gap, in cycles.
REQ-007 The block SHALL have one clock and an asynchronous active-high reset; the ports SHALL be:
- MTxClk  in  1  transmit clock
- Reset  in  1  async reset, active-high
- StateIdle, StatePreamble, StateSoC, StateNumb, StateDelay, StateCrc, StateFrmCrc  in  1 each  one-hot state flags from the tx state machine
- StateDist, StateDelayDist, StateData  in  2 each  two-phase state flags
- PreambleStateEnd, NumbStateEnd, DistStateEnd, DelayStateEnd, CrcStateEnd  out  1 each  state-end pulses
- StartTxDone  out  1  frame complete, idle next cycle
- StCnt  out  8  cycles elapsed in the current counted state
- FrmCnt  out  8  cycles elapsed in StateFrmCrc
- ByteCnt  out  16  data bytes sent in the current frame

Function
REQ-008 Clear condition for StCnt: StateIdle | StateSoC | StateDist[0] | StateDelayDist[0] | StateData[0] | StateData[1] | any *StateEnd output high. When this condition is high, StCnt SHALL load 0 on the next edge.
REQ-009 When the clear condition is low, StCnt SHALL increment by 1 each edge and saturate at 255.
REQ-010 Consequence of REQ-008/009: StCnt SHALL be 0 in the first cycle of Preamble, Numb, Dist[1], Delay and Crc.
REQ-011 PreambleStateEnd = StatePreamble & (StCnt == PRE_NIB-1). This output is combinational.
REQ-012 NumbStateEnd = StateNumb & (StCnt == NUMB_NIB-1).
REQ-013 DistStateEnd = StateDist[1] & (StCnt == DIST_NIB-1).
REQ-014 DelayStateEnd = StateDelay & (StCnt == DELAY_NIB-1).
REQ-015 CrcStateEnd = StateCrc & (StCnt == CRC_NIB-1).
REQ-016 Each end pulse SHALL be high for exactly one cycle per state visit, because StCnt clears on the following edge.
REQ-017 FrmCnt SHALL be 0 whenever StateFrmCrc is low. While StateFrmCrc is high, FrmCnt SHALL increment by 1 per edge and saturate at 255.
REQ-018 StartTxDone = StateFrmCrc & (FrmCnt == FCRC_NIB+IPG_NIB-1). It is combinational and asserts for one cycle.
REQ-019 ByteCnt SHALL clear to 0 while StateIdle is high.
REQ-020 ByteCnt SHALL increment by 1 on each edge where StateData[1] is high, and wrap from 0xFFFF to 0.
REQ-021 ByteCnt SHALL hold its value in every other state, so that it remains readable through Crc and FrmCrc.
REQ-022 Every count limit SHALL lie in the range 1..255, and FCRC_NIB+IPG_NIB SHALL be 255 or less. Any other value is a configuration error, flagged by a simulation-time check.
REQ-023 A Crc state left without CrcStateEnd (direct exit to FrmCrc) SHALL leave StCnt running. No end pulse is due in that case, and StCnt clears in the next counted state's predecessor.
REQ-024 All combinational outputs SHALL depend only on the registered counters and the state inputs. There is no path from an output back to an input.

Reset
REQ-025 While Reset is high, StCnt, FrmCnt and ByteCnt SHALL be 0, independent of MTxClk.
REQ-026 With inputs in the reset state (StateIdle = 1), all end pulses and StartTxDone SHALL be 0.
REQ-027 Reset asserted in the middle of a frame SHALL zero all counters immediately. After release, counting SHALL restart from 0 in the next counted state.

Verification
REQ-028 Preamble: StateIdle for 1 cycle, then StatePreamble held -> PreambleStateEnd high only in the 16th preamble cycle, with StCnt = 15.
REQ-029 Numb: SoC for 1 cycle, then StateNumb held -> NumbStateEnd in the 4th cycle; StCnt is 0 on the next cycle.
REQ-030 Dist: SoC, Dist[0], then Dist[1] held -> DistStateEnd in the 8th Dist[1] cycle, with no pulse during Dist[0].
REQ-031 Data: Data[0]/Data[1] alternating for 5 pairs, then Crc held -> ByteCnt = 5, CrcStateEnd in the 8th Crc cycle, and ByteCnt still 5 during Crc.
REQ-032 Frame end: StateFrmCrc held -> StartTxDone in cycle 32 (FrmCnt = 31); dropping FrmCrc gives FrmCnt = 0 the next cycle.
REQ-033 Mid-frame reset: Reset pulsed with StCnt = 5 in Preamble -> StCnt, FrmCnt and ByteCnt read 0 asynchronously with no end pulse; after re-entering Preamble, the full 16-cycle count is observed.
